// File: rtl/i2s_tx_framed_if.sv
// rtl/i2s_tx_framed_if.sv - stereo sample handshake bundle feeding the serial audio transmitter
interface i2s_tx_framed_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_left;
    logic [DATA_WIDTH-1:0] in_right;

    modport master (
        output in_valid,
        output in_left,
        output in_right,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_left,
        input  in_right,
        output in_ready
    );
endinterface

// File: rtl/i2s_tx_framed.sv
// rtl/i2s_tx_framed.sv - framed stereo I2S / left-justified transmitter with one-frame holding register
module i2s_tx_framed #(
    parameter int DATA_WIDTH      = 16,
    parameter int SLOT_WIDTH      = 32,
    parameter int I2S_MODE        = 1,
    parameter int UNDERRUN_REPEAT = 0
) (
    input  logic                 sclk,
    input  logic                 rst,
    i2s_tx_framed_if.slave       smp,
    output logic                 ws,
    output logic                 sdata,
    output logic                 frame_start,
    output logic                 underrun,
    output logic [7:0]           underrun_cnt
);

    localparam int              FRAME = 2 * SLOT_WIDTH;
    localparam int              CW    = $clog2(FRAME);
    localparam logic [CW-1:0]   LAST  = CW'(FRAME - 1);
    localparam logic [CW-1:0]   S_CNT = CW'(SLOT_WIDTH);
    localparam logic [CW-1:0]   S_M1  = CW'(SLOT_WIDTH - 1);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_next;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_l;
    logic [DATA_WIDTH-1:0] hold_r;
    logic [DATA_WIDTH-1:0] frame_l;
    logic [DATA_WIDTH-1:0] frame_r;
    logic [DATA_WIDTH-1:0] frame_l_next;
    logic [DATA_WIDTH-1:0] frame_r_next;
    logic                  load;
    logic                  accept;
    logic                  ws_next;
    logic                  sdata_next;

    // Bit at frame index idx of the slot words; samples are left-aligned, so
    // shifting past DATA_WIDTH naturally yields the zero padding.
    function automatic logic slot_bit(input logic [DATA_WIDTH-1:0] l,
                                      input logic [DATA_WIDTH-1:0] r,
                                      input logic [CW-1:0]         idx);
        logic [CW-1:0]         p;
        logic [DATA_WIDTH-1:0] w;
        if (idx >= S_CNT) begin
            p = idx - S_CNT;
            w = r;
        end else begin
            p = idx;
            w = l;
        end
        w = w << p;
        return w[DATA_WIDTH-1];
    endfunction

    assign smp.in_ready = !hold_full && !rst;
    assign accept       = smp.in_valid && smp.in_ready;

    always_comb begin
        load         = (cnt == LAST);
        cnt_next     = load ? '0 : cnt + CW'(1);
        frame_l_next = frame_l;
        frame_r_next = frame_r;
        if (load) begin
            if (hold_full) begin
                frame_l_next = hold_l;
                frame_r_next = hold_r;
            end else if (UNDERRUN_REPEAT == 0) begin
                frame_l_next = '0;
                frame_r_next = '0;
            end
        end
        // I2S lags data by one sclk, so it serialises the pre-edge index and
        // frame; that makes k=0 carry the previous frame's final right bit.
        if (I2S_MODE != 0) begin
            ws_next    = (cnt_next >= S_M1) && (cnt_next != LAST);
            sdata_next = slot_bit(frame_l, frame_r, cnt);
        end else begin
            ws_next    = (cnt_next >= S_CNT);
            sdata_next = slot_bit(frame_l_next, frame_r_next, cnt_next);
        end
    end

    always_ff @(negedge sclk) begin
        if (rst) begin
            cnt          <= LAST;
            hold_full    <= 1'b0;
            hold_l       <= '0;
            hold_r       <= '0;
            frame_l      <= '0;
            frame_r      <= '0;
            ws           <= (I2S_MODE == 0);
            sdata        <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 8'd0;
        end else begin
            cnt         <= cnt_next;
            frame_l     <= frame_l_next;
            frame_r     <= frame_r_next;
            ws          <= ws_next;
            sdata       <= sdata_next;
            frame_start <= load;
            underrun    <= load && !hold_full;
            if (load && !hold_full && underrun_cnt != 8'hFF) begin
                underrun_cnt <= underrun_cnt + 8'd1;
            end
            // Accept only happens with holding empty, so it never races a load copy.
            if (accept) begin
                hold_l    <= smp.in_left;
                hold_r    <= smp.in_right;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule
